// File: rtl/edulent_mem_pkg.sv
// -----------------------------------------------------------------------------
// edulent_mem_pkg
// Shared definitions for the two-port memory arbiter slice:
//   MEM_ADDR_W / MEM_DATA_W  default address and data widths
//   port_e                   requester identity (PORT0, PORT1)
//   pend_s                   registered pending read response {valid, port}
// -----------------------------------------------------------------------------
package edulent_mem_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
    } pend_s;

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational arbitration decision for two requesters.
//   valid0, valid1  request present on each port
//   last_grant      port that won the most recent contest; the other port is
//                   favoured when both request
//   grant[1:0]      one-hot grant (bit n = port n), all-zero when idle
// -----------------------------------------------------------------------------
module mem_arb_pick
    import edulent_mem_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  port_e      last_grant,
    output logic [1:0] grant
);

    logic favour1;

    // Port 1 gets the contest only when port 0 was the most recent winner.
    assign favour1 = (last_grant == PORT0);

    assign grant[0] = valid0 & (~valid1 | ~favour1);
    assign grant[1] = valid1 & (~valid0 |  favour1);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-port arbiter in front of a single-port memory with registered read data.
// The granted request drives the memory port in the same cycle; a read
// accepted in cycle N returns its data to the owning port in cycle N+1.
// Writes are posted and produce no response.
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// port 0 has fixed priority and no pointer register exists.
//
// Ports
//   i_clk, i_rstn                      clock, async active-low reset
//   i_pN_valid/we/addr/wdata           request from port N (held until ready)
//   o_pN_ready                         grant / accept for port N
//   o_pN_rvalid, o_pN_rdata            read response for port N (1-cycle pulse)
//   o_mem_addr, o_mem_data_write       memory address and write data
//   o_mem_write_enable                 memory write strobe
//   i_mem_data_read                    memory read data, one cycle after addr
// -----------------------------------------------------------------------------
module mem_arbiter
    import edulent_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rstn,

    input  logic              i_p0_valid,
    input  logic              i_p0_we,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic [DATA_W-1:0] i_p0_wdata,
    output logic              o_p0_ready,
    output logic              o_p0_rvalid,
    output logic [DATA_W-1:0] o_p0_rdata,

    input  logic              i_p1_valid,
    input  logic              i_p1_we,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [DATA_W-1:0] i_p1_wdata,
    output logic              o_p1_ready,
    output logic              o_p1_rvalid,
    output logic [DATA_W-1:0] o_p1_rdata,

    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data_write,
    output logic              o_mem_write_enable,
    input  logic [DATA_W-1:0] i_mem_data_read
);

    logic [1:0]        grant;
    logic              any_grant;
    logic              sel1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W-1:0] last_addr;
    port_e             last_grant;
    pend_s             pend;

    // ------------------------------------------------------------------
    // Arbitration. Requests are masked during reset so no ready can rise
    // while i_rstn is low, even though the valids are live.
    // ------------------------------------------------------------------
    mem_arb_pick u_pick (
        .valid0     (i_p0_valid & i_rstn),
        .valid1     (i_p1_valid & i_rstn),
        .last_grant (last_grant),
        .grant      (grant)
    );

`ifdef MEM_ARB_RR_EN
    // Reset value PORT1 makes port 0 the favoured side of the first contest.
    // The pointer moves only when both ports competed.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            last_grant <= PORT1;
        end else if (i_p0_valid && i_p1_valid) begin
            last_grant <= grant[1] ? PORT1 : PORT0;
        end
    end
`else
    // Constant "port 1 won last" keeps port 0 permanently favoured.
    assign last_grant = PORT1;
`endif

    assign o_p0_ready = grant[0];
    assign o_p1_ready = grant[1];
    assign any_grant  = |grant;
    assign sel1       = grant[1];

    // ------------------------------------------------------------------
    // Memory port mux
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = last_addr;
        sel_wdata = '0;
        if (grant[0]) begin
            sel_we    = i_p0_we;
            sel_addr  = i_p0_addr;
            sel_wdata = i_p0_wdata;
        end else if (grant[1]) begin
            sel_we    = i_p1_we;
            sel_addr  = i_p1_addr;
            sel_wdata = i_p1_wdata;
        end
    end

    assign o_mem_addr         = sel_addr;
    assign o_mem_data_write   = sel_wdata;
    assign o_mem_write_enable = sel_we;

    // ------------------------------------------------------------------
    // Sequential state: held address and the pending read record.
    // Reset clears the record, so a read in flight when reset hits never
    // produces a response.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            last_addr  <= '0;
            pend.valid <= 1'b0;
            pend.port  <= PORT0;
        end else begin
            if (any_grant) begin
                last_addr <= sel_addr;
            end
            pend.valid <= any_grant & ~sel_we;
            pend.port  <= sel1 ? PORT1 : PORT0;
        end
    end

    // ------------------------------------------------------------------
    // Response steering. The memory's registered read data lines up with
    // the pending record; rdata is zeroed on ports without a response.
    // ------------------------------------------------------------------
    assign o_p0_rvalid = pend.valid & (pend.port == PORT0);
    assign o_p1_rvalid = pend.valid & (pend.port == PORT1);
    assign o_p0_rdata  = o_p0_rvalid ? i_mem_data_read : '0;
    assign o_p1_rdata  = o_p1_rvalid ? i_mem_data_read : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A registered read-before-write memory
// sits on the memory port; a transaction-level model (shadow memory, contest
// winner, expected response) predicts grants and responses each cycle.
// Define MEM_ARB_RR_EN for both bench and RTL to check the round-robin build.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    always #5 clk = ~clk;

    logic          p0_valid, p0_we, p1_valid, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_ready, p1_ready, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk              (clk),
        .i_rstn             (rstn),
        .i_p0_valid         (p0_valid),
        .i_p0_we            (p0_we),
        .i_p0_addr          (p0_addr),
        .i_p0_wdata         (p0_wdata),
        .o_p0_ready         (p0_ready),
        .o_p0_rvalid        (p0_rvalid),
        .o_p0_rdata         (p0_rdata),
        .i_p1_valid         (p1_valid),
        .i_p1_we            (p1_we),
        .i_p1_addr          (p1_addr),
        .i_p1_wdata         (p1_wdata),
        .o_p1_ready         (p1_ready),
        .o_p1_rvalid        (p1_rvalid),
        .o_p1_rdata         (p1_rdata),
        .o_mem_addr         (mem_addr),
        .o_mem_data_write   (mem_wdata),
        .o_mem_write_enable (mem_we),
        .i_mem_data_read    (mem_rdata)
    );

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 'h10) return 8'hA5;
        return DW'((i * 37 + 11) & 'hFF);
    endfunction

    // Memory environment: registered read data, read-before-write.
    logic [DW-1:0] mem [0:255];
    bit            loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            loaded <= 1'b1;
        end else begin
            mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    // Reference model state
    logic [DW-1:0] shadow [0:255];
    int            last_winner;      // port that won the latest contest
    bit            pv;               // response expected this cycle
    int            pport;
    logic [DW-1:0] pdata;
    logic [AW-1:0] m_last_addr;

    int tests = 0;
    int fails = 0;

    // Per-cycle observations for scenario-level checks
    bit            acc0, acc1;
    logic          obs_rv0, obs_rv1;
    logic [DW-1:0] obs_rd0, obs_rd1;

    task automatic model_reset();
        pv          = 1'b0;
        pport       = 0;
        last_winner = 1;
        m_last_addr = '0;
    endtask

    // One clock cycle: predict and compare at the falling edge, then advance
    // the model past the rising edge. Inputs must already be driven.
    task automatic do_cycle();
        bit            p0_first, e0, e1, ewe;
        logic [AW-1:0] ea;
        @(negedge clk);
        p0_first = RR ? (last_winner == 1) : 1'b1;
        e0  = p0_valid && (!p1_valid || p0_first);
        e1  = p1_valid && !e0;
        ea  = e0 ? p0_addr : (e1 ? p1_addr : m_last_addr);
        ewe = e0 ? p0_we : (e1 ? p1_we : 1'b0);

        tests++;
        if (p0_ready !== e0) begin fails++; $display("FAIL p0_ready: got %b want %b", p0_ready, e0); end
        tests++;
        if (p1_ready !== e1) begin fails++; $display("FAIL p1_ready: got %b want %b", p1_ready, e1); end
        tests++;
        if (mem_addr !== ea) begin fails++; $display("FAIL mem_addr: got %h want %h", mem_addr, ea); end
        tests++;
        if (mem_we !== ewe) begin fails++; $display("FAIL mem_we: got %b want %b", mem_we, ewe); end
        if (ewe) begin
            tests++;
            if (mem_wdata !== (e0 ? p0_wdata : p1_wdata)) begin
                fails++;
                $display("FAIL mem_wdata: got %h want %h", mem_wdata, e0 ? p0_wdata : p1_wdata);
            end
        end
        tests++;
        if (p0_rvalid !== (pv && pport == 0)) begin
            fails++; $display("FAIL p0_rvalid: got %b want %b", p0_rvalid, pv && pport == 0);
        end
        tests++;
        if (p1_rvalid !== (pv && pport == 1)) begin
            fails++; $display("FAIL p1_rvalid: got %b want %b", p1_rvalid, pv && pport == 1);
        end
        if (pv) begin
            tests++;
            if ((pport == 0 ? p0_rdata : p1_rdata) !== pdata) begin
                fails++;
                $display("FAIL p%0d_rdata: got %h want %h", pport, pport == 0 ? p0_rdata : p1_rdata, pdata);
            end
        end
        acc0 = e0; acc1 = e1;
        obs_rv0 = p0_rvalid; obs_rv1 = p1_rvalid;
        obs_rd0 = p0_rdata;  obs_rd1 = p1_rdata;

        @(posedge clk);
        #1;
        if (p0_valid && p1_valid) last_winner = e0 ? 0 : 1;
        pv    = (e0 || e1) && !ewe;
        pport = e1 ? 1 : 0;
        pdata = shadow[ea];
        if (ewe) shadow[ea] = e0 ? p0_wdata : p1_wdata;
        if (e0 || e1) m_last_addr = ea;
    endtask

    task automatic idle_inputs();
        p0_valid = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_valid = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    endtask

    // Run until both ports have been accepted, then one drain cycle.
    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        while ((p0_valid || p1_valid) && n < max_cycles) begin
            do_cycle();
            if (acc0) p0_valid = 0;
            if (acc1) p1_valid = 0;
            n++;
        end
        tests++;
        if (p0_valid || p1_valid) begin
            fails++; $display("FAIL drain_timeout: pending %b%b want 00", p0_valid, p1_valid);
            idle_inputs();
        end
        do_cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        if ({p0_ready, p1_ready, p0_rvalid, p1_rvalid, mem_we} !== 5'b0 ||
            p0_rdata !== '0 || p1_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            fails++;
            $display("FAIL %s: rdy %b%b rv %b%b we %b rd %h/%h addr %h wd %h want all 0", tag,
                     p0_ready, p1_ready, p0_rvalid, p1_rvalid, mem_we, p0_rdata, p1_rdata,
                     mem_addr, mem_wdata);
        end
    endtask

    task automatic do_reset();
        rstn = 0;
        p0_valid = 1; p0_we = 1; p0_addr = 8'h33; p0_wdata = 8'h77;
        p1_valid = 1; p1_we = 0; p1_addr = 8'h44; p1_wdata = 8'h88;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_outputs");
        idle_inputs();
        @(posedge clk);
        #1;
        rstn = 1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        do_cycle();
    endtask

    task automatic test_single_read();
        p0_valid = 1; p0_we = 0; p0_addr = 8'h10;
        do_cycle();
        tests++;
        if (acc0 !== 1'b1) begin fails++; $display("FAIL single_read_grant: got %b want 1", acc0); end
        idle_inputs();
        do_cycle();
        tests++;
        if (obs_rv0 !== 1'b1 || obs_rd0 !== 8'hA5 || obs_rv1 !== 1'b0) begin
            fails++;
            $display("FAIL single_read_resp: rv0 %b rd0 %h rv1 %b want 1 a5 0", obs_rv0, obs_rd0, obs_rv1);
        end
    endtask

    task automatic test_write_then_read();
        p1_valid = 1; p1_we = 1; p1_addr = 8'h20; p1_wdata = 8'h3C;
        do_cycle();
        idle_inputs();
        p0_valid = 1; p0_we = 0; p0_addr = 8'h20;
        do_cycle();
        tests++;
        if (obs_rv0 !== 1'b0 || obs_rv1 !== 1'b0) begin
            fails++; $display("FAIL write_no_rvalid: rv %b%b want 00", obs_rv0, obs_rv1);
        end
        idle_inputs();
        do_cycle();
        tests++;
        if (obs_rv0 !== 1'b1 || obs_rd0 !== 8'h3C) begin
            fails++; $display("FAIL write_then_read: rv0 %b rd0 %h want 1 3c", obs_rv0, obs_rd0);
        end
    endtask

    task automatic test_contention();
        int seq [4];
        int exp_seq [4];
        do_reset();
        p0_valid = 1; p0_we = 0; p0_addr = 8'h01;
        p1_valid = 1; p1_we = 0; p1_addr = 8'h81;
        for (int i = 0; i < 4; i++) begin
            do_cycle();
            seq[i] = acc1 ? 1 : 0;
            exp_seq[i] = RR ? (i % 2) : 0;
            if (acc0) p0_addr = p0_addr + 1;
            if (acc1) p1_addr = p1_addr + 1;
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (seq[i] !== exp_seq[i]) begin
                fails++; $display("FAIL contention_grant[%0d]: got p%0d want p%0d", i, seq[i], exp_seq[i]);
            end
        end
        p1_valid = 0;
        run_until_idle(4);
        idle_inputs();
    endtask

    task automatic test_reset_pending();
        do_reset();
        p1_valid = 1; p1_we = 0; p1_addr = 8'h10;
        do_cycle();
        rstn = 0;
        p1_valid = 1; p0_valid = 1; p0_we = 0; p0_addr = 8'h05;
        @(negedge clk);
        check_reset_outputs("reset_pending_outputs");
        @(posedge clk);
        #1;
        rstn = 1;
        model_reset();
        p1_addr = 8'h06;
        do_cycle();
        tests++;
        if (obs_rv1 !== 1'b0) begin fails++; $display("FAIL reset_pending_rvalid: got %b want 0", obs_rv1); end
        tests++;
        if (acc0 !== 1'b1) begin fails++; $display("FAIL post_reset_winner: got p%0d want p0", acc1 ? 1 : 0); end
        p0_valid = 0;
        run_until_idle(4);
        idle_inputs();
    endtask

    task automatic same_addr_round(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                   input bit p1_first);
        logic [DW-1:0] old_val;
        logic [DW-1:0] got;
        logic [DW-1:0] want;
        bit            seen = 1'b0;
        int            n = 0;
        old_val = shadow[a];
        p0_valid = 1; p0_we = 1; p0_addr = a; p0_wdata = wd;
        p1_valid = 1; p1_we = 0; p1_addr = a;
        got = '0;
        while (n < 4) begin
            do_cycle();
            if (obs_rv1) begin seen = 1'b1; got = obs_rd1; end
            if (acc0) p0_valid = 0;
            if (acc1) p1_valid = 0;
            n++;
        end
        want = p1_first ? old_val : wd;
        tests++;
        if (!seen || got !== want) begin
            fails++; $display("FAIL same_addr %h: seen %b rd1 %h want %h", a, seen, got, want);
        end
    endtask

    task automatic test_same_addr();
        do_reset();
        same_addr_round(8'h40, 8'h55, 1'b0);
        // After port 0 won the first contest, round-robin favours port 1.
        same_addr_round(8'h41, 8'h66, RR);
        idle_inputs();
    endtask

    task automatic rand_req(output logic v, output logic we,
                            output logic [AW-1:0] a, output logic [DW-1:0] d);
        v  = ($urandom_range(0, 3) != 0);
        we = ($urandom_range(0, 2) == 0);
        a  = AW'($urandom_range(0, 31));
        d  = DW'($urandom);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!p0_valid || acc0) rand_req(p0_valid, p0_we, p0_addr, p0_wdata);
            if (!p1_valid || acc1) rand_req(p1_valid, p1_we, p1_addr, p1_wdata);
            do_cycle();
        end
        if (acc0) p0_valid = 0;
        if (acc1) p1_valid = 0;
        run_until_idle(4);
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        idle_inputs();
        model_reset();
        acc0 = 0; acc1 = 0;
        rstn = 0;
        test_reset();
        test_single_read();
        test_write_then_read();
        test_contention();
        test_reset_pending();
        test_same_addr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width in bits.
REQ-002 Parameter DATA_W, default 8, memory data width in bits.
REQ-003 i_clk  input  1  clock; all state changes on its rising edge.
REQ-004 i_rstn  input  1  reset, asynchronous, active-low.
REQ-005 i_p0_valid / i_p1_valid  input  1  port request present.
REQ-006 i_p0_we / i_p1_we  input  1  request is a write (1) or a read (0).
REQ-007 i_p0_addr / i_p1_addr  input  ADDR_W  request address.
REQ-008 i_p0_wdata / i_p1_wdata  input  DATA_W  write data.
REQ-009 o_p0_ready / o_p1_ready  output  1  grant; the request is accepted when valid and ready are both high.
REQ-010 o_p0_rvalid / o_p1_rvalid  output  1  read data valid; single-cycle pulse.
REQ-011 o_p0_rdata / o_p1_rdata  output  DATA_W  read data.
REQ-012 o_mem_addr, o_mem_data_write  output  ADDR_W / DATA_W  drive the memory port.
REQ-013 o_mem_write_enable  output  1  memory write strobe.
REQ-014 i_mem_data_read  input  DATA_W  memory registered read data, valid one cycle after the address.

Function
REQ-015 At most one ready per cycle; ready is combinational from the valids and the arbitration state, and never depends on its own port's ready.
REQ-016 Only one valid high: that port is granted in the same cycle.
REQ-017 Both valids high: the winner is chosen per REQ-030/031.
REQ-018 Granted request drives o_mem_addr, o_mem_data_write and o_mem_write_enable (= we) combinationally in the same cycle.
REQ-019 No grant: o_mem_write_enable = 0, and o_mem_addr holds the last granted address.
REQ-020 Read accepted in cycle N: the owning port sees rvalid = 1 in cycle N+1, with rdata = i_mem_data_read.
REQ-021 The pending-response record is a registered {valid, port} pair.
REQ-022 Back-to-back reads, including alternating ports, sustain one accept per cycle with no bubbles.
REQ-023 Writes are posted: no rvalid is generated.
REQ-024 Read data to a port whose rvalid is low is don't-care; verification treats it as X.
REQ-025 A port holds valid, we, addr and wdata stable until accepted; the arbiter never drops an un-accepted request.
REQ-026 Read and write to the same address on consecutive cycles: the read returns the memory's read-before-write value; no forwarding.

Reset
REQ-027 While i_rstn = 0: ready, rvalid and o_mem_write_enable are 0; rdata, o_mem_addr and o_mem_data_write are 0; the pending record is cleared.
REQ-028 After reset, the priority pointer selects port 0.
REQ-029 Reset asserted with a read pending: the response is discarded, with no rvalid after deassertion.

Configuration
REQ-030 With MEM_ARB_RR_EN defined: round-robin arbitration. A registered last-grant pointer updates on each contested grant, and the port not granted most recently wins the next contest.
REQ-031 Without MEM_ARB_RR_EN: fixed priority, port 0 always wins; the pointer register is absent.

Structure
REQ-032 A shared package, edulent_mem_pkg, holds ADDR_W/DATA_W defaults and a port-id enum (PORT0, PORT1).
REQ-033 The shared package also holds the pending-response struct {valid, port}.
REQ-034 Arbitration decision in a sub-module, mem_arb_pick: combinational valids + pointer -> one-hot grant.
REQ-035 mem_arbiter holds the sequential state; memory instantiation is the parent's job.

Verification
REQ-036 Reset release: p0 read of 0x10 (holding 0xA5) -> p0_ready in cycle 0, p0_rvalid = 1 with rdata = 0xA5 in cycle 1, p1_rvalid = 0.
REQ-037 p1 write 0x3C to 0x20, then p0 read 0x20 next cycle -> p0_rdata = 0x3C; no rvalid for the write.
REQ-038 Both ports reading for 4 cycles under RR -> grants p0,p1,p0,p1; each rvalid goes to the matching port one cycle later.
REQ-039 Both ports reading for 4 cycles under fixed priority -> grants p0,p0,p0,p0; p1 stalls with stable inputs.
REQ-040 Reset asserted the cycle after a p1 read accept -> no p1_rvalid, all outputs 0 during reset, first post-reset contest won by p0.
REQ-041 Same-address write (p0, 0x55) and read (p1) contended in one cycle -> the loser is served the next cycle; the read returns pre-write data only if it was granted first.
